// File: rtl/btn_conditioner_if.sv
// Front-panel button bundle: raw buttons in, conditioned levels/pulses and key code out.
// The master side is the conditioner; the slave side is the panel/consumer.
interface btn_conditioner_if;
    logic [15:0] i_btns_raw;
    logic [15:0] o_btns;
    logic [15:0] o_press;
    logic [15:0] o_release;
    logic        o_key_valid;
    logic [3:0]  o_key_code;

    modport master (
        input  i_btns_raw,
        output o_btns, o_press, o_release, o_key_valid, o_key_code
    );

    modport slave (
        output i_btns_raw,
        input  o_btns, o_press, o_release, o_key_valid, o_key_code
    );
endinterface

// File: rtl/btn_conditioner.sv
// 16-button synchroniser, debouncer, edge detector and auto-repeat with a priority key code.
// Level change visible DEBOUNCE_MS+2 edges after a stable raw edge; no backpressure, pulses are one cycle.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_MS  = 20,
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100,
    parameter logic [15:0] REPEAT_EN    = 16'h0000
) (
    input  logic             clk_1kHz,
    input  logic             resetn,
    btn_conditioner_if.master bus
);

    localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_MS - 1);
    localparam logic [9:0] DLY_LAST  = 10'(REPEAT_DELAY - 1);
    localparam logic [9:0] RATE_LAST = 10'(REPEAT_RATE - 1);

    logic [15:0] sync1, sync2, level, press_q, rel_q, rpt;
    logic [7:0]  deb_cnt  [16];
    logic [9:0]  hold_cnt [16];

    logic [15:0] accept, rise, fall, rep_hit, rpt_nxt;
    logic [7:0]  deb_nxt  [16];
    logic [9:0]  hold_nxt [16];
    logic [3:0]  key_code;

    always_comb begin
        accept  = '0;
        rise    = '0;
        fall    = '0;
        rep_hit = '0;
        rpt_nxt = '0;
        for (int i = 0; i < 16; i++) begin
            deb_nxt[i]  = '0;
            hold_nxt[i] = '0;
            accept[i]   = (sync2[i] != level[i]) && (deb_cnt[i] == DEB_LAST);
            if ((sync2[i] != level[i]) && !accept[i])
                deb_nxt[i] = deb_cnt[i] + 8'd1;
            rise[i] = accept[i] & sync2[i];
            fall[i] = accept[i] & ~sync2[i];
            // A release in this cycle suppresses a repeat that would land on the same edge.
            rep_hit[i] = REPEAT_EN[i] & level[i] & ~fall[i] &
                         (rpt[i] ? (hold_cnt[i] == RATE_LAST) : (hold_cnt[i] == DLY_LAST));
            if (REPEAT_EN[i] && level[i] && !fall[i]) begin
                if (rep_hit[i]) begin
                    rpt_nxt[i] = 1'b1;
                end else begin
                    hold_nxt[i] = hold_cnt[i] + 10'd1;
                    rpt_nxt[i]  = rpt[i];
                end
            end
        end
    end

    always_ff @(posedge clk_1kHz or negedge resetn) begin
        if (!resetn) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            press_q <= '0;
            rel_q   <= '0;
            rpt     <= '0;
            for (int i = 0; i < 16; i++) begin
                deb_cnt[i]  <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            sync1   <= bus.i_btns_raw;
            sync2   <= sync1;
            level   <= level ^ accept;
            press_q <= rise | rep_hit;
            rel_q   <= fall;
            rpt     <= rpt_nxt;
            for (int i = 0; i < 16; i++) begin
                deb_cnt[i]  <= deb_nxt[i];
                hold_cnt[i] <= hold_nxt[i];
            end
        end
    end

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        key_code = '0;
        for (int i = 15; i >= 0; i--) begin
            if (press_q[i])
                key_code = 4'(i);
        end
    end

    assign bus.o_btns      = level;
    assign bus.o_press     = press_q;
    assign bus.o_release   = rel_q;
    assign bus.o_key_valid = |press_q;
    assign bus.o_key_code  = key_code;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed stimulus pushes expected output events (cycle, levels, pulses, key code) into a queue;
// the monitor pops one entry whenever the DUT shows a pulse or a level change, and checks all-zero outputs in reset.
module tb_btn_conditioner;

    typedef struct {
        int          cyc;
        logic [15:0] btns;
        logic [15:0] press;
        logic [15:0] rel;
        logic [3:0]  code;
    } exp_t;

    logic clk;
    logic resetn;
    logic done;
    int   cyc;
    int   n_cmp;
    int   n_err;
    exp_t exp_q[$];

    btn_conditioner_if bus();

    btn_conditioner #(
        .DEBOUNCE_MS  (20),
        .REPEAT_DELAY (500),
        .REPEAT_RATE  (100),
        .REPEAT_EN    (16'h0001)
    ) dut (
        .clk_1kHz (clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_ev(input int c, input logic [15:0] b, input logic [15:0] p,
                             input logic [15:0] r, input logic [3:0] k);
        exp_t e;
        e.cyc = c; e.btns = b; e.press = p; e.rel = r; e.code = k;
        exp_q.push_back(e);
    endtask

    // Inputs change 1 time unit after an edge, so the next edge is the capture edge.
    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stimulus
    initial begin
        int p;
        int last;
        done           = 1'b0;
        resetn         = 1'b0;
        bus.i_btns_raw = 16'hFFFF;
        repeat (4) @(posedge clk);
        #1;

        // All buttons held through reset release count as a fresh press.
        resetn = 1'b1;
        expect_ev(cyc + 22, 16'hFFFF, 16'hFFFF, 16'h0000, 4'd0);
        step_to(cyc + 40);
        bus.i_btns_raw = 16'h0000;
        expect_ev(cyc + 22, 16'h0000, 16'h0000, 16'hFFFF, 4'd0);
        step_to(cyc + 30);

        // Bounce on button 3: five 3-cycle toggles ending high.
        for (int k = 0; k < 5; k++) begin
            bus.i_btns_raw[3] = ~bus.i_btns_raw[3];
            if (k < 4) step_to(cyc + 3);
        end
        last = cyc;
        expect_ev(last + 22, 16'h0008, 16'h0008, 16'h0000, 4'd3);
        step_to(last + 40);
        bus.i_btns_raw[3] = 1'b0;
        expect_ev(cyc + 22, 16'h0000, 16'h0000, 16'h0008, 4'd0);
        step_to(cyc + 30);

        // 19-cycle glitch on button 7 is one sample short of acceptance.
        bus.i_btns_raw[7] = 1'b1;
        step_to(cyc + 19);
        bus.i_btns_raw[7] = 1'b0;
        step_to(cyc + 40);

        // Auto-repeat on button 0 only; release lands on the edge of the 4th repeat.
        bus.i_btns_raw[1:0] = 2'b11;
        p = cyc + 22;
        expect_ev(p,       16'h0003, 16'h0003, 16'h0000, 4'd0);
        expect_ev(p + 500, 16'h0003, 16'h0001, 16'h0000, 4'd0);
        expect_ev(p + 600, 16'h0003, 16'h0001, 16'h0000, 4'd0);
        expect_ev(p + 700, 16'h0003, 16'h0001, 16'h0000, 4'd0);
        step_to(p + 778);
        bus.i_btns_raw[1:0] = 2'b00;
        expect_ev(p + 800, 16'h0000, 16'h0000, 16'h0003, 4'd0);
        step_to(cyc + 30);

        // Simultaneous press of 9 and 5.
        bus.i_btns_raw = 16'h0220;
        expect_ev(cyc + 22, 16'h0220, 16'h0220, 16'h0000, 4'd5);
        step_to(cyc + 30);
        bus.i_btns_raw = 16'h0000;
        expect_ev(cyc + 22, 16'h0000, 16'h0000, 16'h0220, 4'd0);
        step_to(cyc + 30);

        // Reset while button 0 is repeating and still held.
        bus.i_btns_raw[0] = 1'b1;
        p = cyc + 22;
        expect_ev(p,       16'h0001, 16'h0001, 16'h0000, 4'd0);
        expect_ev(p + 500, 16'h0001, 16'h0001, 16'h0000, 4'd0);
        step_to(p + 550);
        #1;
        resetn = 1'b0;
        step_to(cyc + 5);
        resetn = 1'b1;
        p = cyc + 22;
        expect_ev(p,       16'h0001, 16'h0001, 16'h0000, 4'd0);
        expect_ev(p + 500, 16'h0001, 16'h0001, 16'h0000, 4'd0);
        step_to(p + 510);
        bus.i_btns_raw[0] = 1'b0;
        expect_ev(cyc + 22, 16'h0000, 16'h0000, 16'h0001, 4'd0);
        step_to(cyc + 40);
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        logic [15:0] btns_prev;
        exp_t        e;
        n_cmp     = 0;
        n_err     = 0;
        btns_prev = '0;
        while (!done) begin
            @(negedge clk);
            if (!resetn) begin
                n_cmp++;
                if (bus.o_btns !== 16'h0 || bus.o_press !== 16'h0 || bus.o_release !== 16'h0 ||
                    bus.o_key_valid !== 1'b0 || bus.o_key_code !== 4'd0) begin
                    n_err++;
                    $display("FAIL reset_zero @cyc %0d: got btns=%h press=%h rel=%h vld=%b code=%0d, want all 0",
                             cyc, bus.o_btns, bus.o_press, bus.o_release, bus.o_key_valid, bus.o_key_code);
                end
                btns_prev = '0;
            end else begin
                if (bus.o_press !== 16'h0 || bus.o_release !== 16'h0 || bus.o_btns !== btns_prev) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_event @cyc %0d: got btns=%h press=%h rel=%h code=%0d, want no event",
                                 cyc, bus.o_btns, bus.o_press, bus.o_release, bus.o_key_code);
                    end else begin
                        e = exp_q.pop_front();
                        if (cyc != e.cyc || bus.o_btns !== e.btns || bus.o_press !== e.press ||
                            bus.o_release !== e.rel || bus.o_key_code !== e.code ||
                            bus.o_key_valid !== (|e.press)) begin
                            n_err++;
                            $display("FAIL event: got cyc=%0d btns=%h press=%h rel=%h code=%0d vld=%b, want cyc=%0d btns=%h press=%h rel=%h code=%0d vld=%b",
                                     cyc, bus.o_btns, bus.o_press, bus.o_release, bus.o_key_code, bus.o_key_valid,
                                     e.cyc, e.btns, e.press, e.rel, e.code, |e.press);
                        end
                    end
                end
                btns_prev = bus.o_btns;
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_event: got nothing, want cyc=%0d btns=%h press=%h rel=%h code=%0d",
                     e.cyc, e.btns, e.press, e.rel, e.code);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Per-button input conditioner for the 16-button front panel. It synchronises, debounces and edge-detects the raw panel buttons, then feeds clean levels and one-cycle press pulses to the demux and mode modules: counter, time setting, world clock, stopwatch, piano and text. It also provides optional auto-repeat for held buttons, which suits time-setting increments. A priority-encoded key code serves consumers that need a single key index.

## Interface

Parameters:

- DEBOUNCE_MS, default 20: consecutive stable samples required to accept a level change. Range 1..255.
- REPEAT_DELAY, default 500: cycles a button is held before the first auto-repeat pulse. Range 1..1023.
- REPEAT_RATE, default 100: cycles between subsequent auto-repeat pulses. Range 1..1023.
- REPEAT_EN, default 16'h0000: per-button mask. A bit set to 1 enables auto-repeat on that button.

Ports:

- clk_1kHz, input, 1: the single clock, 1 kHz. All logic is on the rising edge.
- resetn, input, 1: asynchronous, active-low reset.
- i_btns_raw, input, 16: raw panel buttons, active-high, asynchronous and bouncing.
- o_btns, output, 16: debounced button levels.
- o_press, output, 16: one-cycle pulse per button on an accepted press and on each auto-repeat.
- o_release, output, 16: one-cycle pulse per button on an accepted release.
- o_key_valid, output, 1: equals |o_press.
- o_key_code, output, 4: index of the lowest-numbered set bit of o_press. It is 0 when o_key_valid is 0.

## Operation

- **Synchroniser.** Each bit passes through a 2-flop synchroniser (sync1 → sync2). Both flops reset to 0.
- **Debounce, per button i.** The state is the level L[i] and an 8-bit counter D[i].
  - When sync2[i] == L[i], D[i] <= 0.
  - When sync2[i] != L[i] and D[i] == DEBOUNCE_MS-1: L[i] <= sync2[i] and D[i] <= 0.
  - Otherwise D[i] <= D[i]+1.
  - Any bounce back to L[i] before acceptance clears D[i], so the count restarts.
- **Outputs from the level.** o_btns = L (registered).
  - o_press[i] is registered. It is 1 for exactly one cycle, the cycle in which L[i] first reads 1.
  - o_release[i] is the same, for the cycle in which L[i] first reads 0.
- **Auto-repeat, per button i with REPEAT_EN[i] = 1.** The state is a 10-bit hold counter H[i] and a flag R[i].
  - While L[i] = 0: H[i] = 0 and R[i] = 0.
  - While L[i] = 1 and R[i] = 0: H[i] increments each cycle. When H[i] reaches REPEAT_DELAY, o_press[i] pulses, R[i] <= 1 and H[i] <= 0.
  - While R[i] = 1: H[i] increments. When H[i] reaches REPEAT_RATE, o_press[i] pulses and H[i] <= 0.
  - When REPEAT_EN[i] = 0, H[i] and R[i] stay 0 and no repeat pulses occur.
- **Key encoder.** o_key_code and o_key_valid are combinational from the registered o_press.
- **Simultaneous events.**
  - Buttons are fully independent. Several o_press bits may be set in one cycle; o_key_code then reports the lowest index.
  - The initial press pulse and the repeat pulse never coincide, because H starts at 0 on the press cycle.
  - Release wins over a pending repeat. In the cycle L[i] falls, o_press[i] = 0, o_release[i] = 1, and H[i] and R[i] clear.
- **Reset.** Asynchronous assertion clears sync1, sync2, L, D, H, R, o_press and o_release. All outputs are 0 during and immediately after reset.
  - A button held through reset release is treated as a new press. After synchronisation and debounce, L rises and o_press pulses once.
  - Reset asserted mid-debounce or mid-repeat discards all progress.

## Timing

- Latency from a raw edge (raw stable from clock edge t) to the L/o_btns change visible after edge t+DEBOUNCE_MS+1 is DEBOUNCE_MS+2 edges, counting the capture edge.
  - With the default of 20, this is 22 cycles = 22 ms.
- o_press and o_release are aligned with the first cycle of the new o_btns value.
- With the defaults, the first repeat pulse comes REPEAT_DELAY = 500 cycles after the initial press pulse. Further pulses follow every REPEAT_RATE = 100 cycles.
- Minimum accepted pulse width on i_btns_raw is DEBOUNCE_MS cycles. Shorter glitches produce no output change.
- No combinational path from i_btns_raw to any output.

## Test plan

- **Reset values.** Drive resetn = 0 with i_btns_raw = 16'hFFFF, then release → all outputs 0 during reset. After release, o_btns = 16'hFFFF on the 22nd edge, and o_press = 16'hFFFF for exactly 1 cycle with o_key_code = 0.
- **Bounce rejection.** On i_btns_raw[3], apply 5 toggles of 3 cycles each, then hold stable 1 → o_btns[3] rises exactly 22 cycles after the last raw edge, with a single o_press[3] pulse and o_key_code = 3. No earlier changes.
- **Glitch.** Hold i_btns_raw[7] high for 19 cycles, then low → o_btns, o_press and o_release stay 0 throughout.
- **Auto-repeat.** Set REPEAT_EN = 16'h0001 and hold button 0 for 800 cycles after acceptance → o_press[0] pulses at relative cycles 0, 500, 600 and 700. On release, o_release[0] pulses once 22 cycles after the raw fall and no further o_press occurs. Button 1 held for the same duration gives only the cycle-0 pulse.
- **Simultaneous press.** Raise buttons 9 and 5 on the same edge → o_press = 16'h0220 for one cycle, o_key_code = 5, o_key_valid = 1.
- **Mid-operation reset.** Assert resetn while button 0 is repeating (REPEAT_EN[0] = 1), with the button still held → all outputs go 0 asynchronously. After release, a fresh press pulse arrives 22 cycles later and the next repeat comes 500 cycles after that.
